// File: rtl/vram_dma.sv
// rtl/vram_dma.sv - CPU-programmed system-memory to VRAM copy engine
// Copies bytes only while the GPU reports writable; pauses and resumes across vblanks.
module vram_dma #(
  parameter int VRAM_ADDR_WIDTH = 12,
  parameter int SRC_ADDR_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 reg_addr,
  input  logic [7:0]                 reg_wdata,
  input  logic                       reg_we,
  output logic [7:0]                 status,
  input  logic                       writable,
  output logic                       bus_req,
  input  logic                       bus_gnt,
  output logic [SRC_ADDR_WIDTH-1:0]  src_addr,
  output logic                       src_rd_en,
  input  logic [7:0]                 src_rdata,
  output logic [7:0]                 vram_data,
  output logic [VRAM_ADDR_WIDTH-1:0] vram_address,
  output logic                       vram_we,
  output logic                       vram_select,
  output logic                       done_irq
);

  localparam int DHW = VRAM_ADDR_WIDTH - 8;
  localparam logic [SRC_ADDR_WIDTH-1:0]  SRC_ONE = 1;
  localparam logic [VRAM_ADDR_WIDTH-1:0] DST_ONE = 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT_VB, S_REQ, S_RD, S_WR, S_DONE} state_t;
  state_t state, state_nx;

  logic [7:0]                 src_lo, src_hi, dst_lo, len;
  logic [DHW-1:0]             dst_hi;
  logic [15:0]                src_cfg;
  logic [SRC_ADDR_WIDTH-1:0]  src;
  logic [VRAM_ADDR_WIDTH-1:0] dst;
  logic [8:0]                 remaining;
  logic                       rd_q;
  logic [7:0]                 data_hold;
  logic                       ctrl_we, start, abort, clr_irq, write_now, last_byte;

  assign src_cfg   = {src_hi, src_lo};
  assign ctrl_we   = reg_we && (reg_addr == 3'd5);
  assign start     = ctrl_we && reg_wdata[0];
  assign abort     = ctrl_we && reg_wdata[1];
  assign clr_irq   = ctrl_we && reg_wdata[2];
  assign write_now = (state == S_WR) && bus_gnt;
  assign last_byte = (remaining == 9'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      src_lo    <= '0;
      src_hi    <= '0;
      dst_lo    <= '0;
      dst_hi    <= '0;
      len       <= '0;
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
      rd_q      <= 1'b0;
      data_hold <= '0;
      done_irq  <= 1'b0;
    end else begin
      state <= state_nx;
      rd_q  <= (state == S_RD);
      // src_rdata is only valid in the first WR clk; keep a copy for a WR held off by bus_gnt
      if (rd_q)
        data_hold <= src_rdata;
      if (reg_we && state == S_IDLE) begin
        case (reg_addr)
          3'd0:    src_lo <= reg_wdata;
          3'd1:    src_hi <= reg_wdata;
          3'd2:    dst_lo <= reg_wdata;
          3'd3:    dst_hi <= reg_wdata[DHW-1:0];
          3'd4:    len    <= reg_wdata;
          default: ;
        endcase
      end
      if (state == S_IDLE && start) begin
        src       <= src_cfg[SRC_ADDR_WIDTH-1:0];
        dst       <= {dst_hi, dst_lo};
        remaining <= (len == 8'd0) ? 9'd256 : {1'b0, len};
      end
      if (write_now && !abort) begin
        src       <= src + SRC_ONE;
        dst       <= dst + DST_ONE;
        remaining <= remaining - 9'd1;
      end
      // completion takes priority over a same-clk clear
      if (write_now && last_byte && !abort)
        done_irq <= 1'b1;
      else if (clr_irq)
        done_irq <= 1'b0;
    end
  end

  always_comb begin
    state_nx     = state;
    bus_req      = 1'b0;
    src_rd_en    = 1'b0;
    src_addr     = '0;
    vram_we      = 1'b0;
    vram_select  = 1'b0;
    vram_address = '0;
    vram_data    = '0;
    case (state)
      S_IDLE:    if (start) state_nx = S_WAIT_VB;
      S_WAIT_VB: if (writable) state_nx = S_REQ;
      S_REQ: begin
        bus_req = 1'b1;
        if (!writable)    state_nx = S_WAIT_VB;
        else if (bus_gnt) state_nx = S_RD;
      end
      S_RD: begin
        bus_req   = 1'b1;
        src_rd_en = 1'b1;
        src_addr  = src;
        state_nx  = S_WR;
      end
      S_WR: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          vram_we      = 1'b1;
          vram_select  = 1'b1;
          vram_address = dst;
          vram_data    = rd_q ? src_rdata : data_hold;
          if (last_byte)     state_nx = S_DONE;
          else if (writable) state_nx = S_RD;
          else               state_nx = S_WAIT_VB;
        end else if (!writable) begin
          state_nx = S_WAIT_VB;
        end
      end
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
    if (abort && state != S_IDLE)
      state_nx = S_IDLE;
  end

  assign status = {5'b0, done_irq, (state == S_WAIT_VB), (state != S_IDLE)};

endmodule
